// File: rtl/gate_pkg.sv
// Shared types and the per-bit gate function for the gate_array_pipe datapath.
package gate_pkg;

  typedef enum logic [2:0] {
    GATE_NAND  = 3'd0,
    GATE_AND   = 3'd1,
    GATE_OR    = 3'd2,
    GATE_NOR   = 3'd3,
    GATE_XOR   = 3'd4,
    GATE_XNOR  = 3'd5,
    GATE_NOT_A = 3'd6,
    GATE_BUF_A = 3'd7
  } gate_op_e;

  localparam int unsigned STAGES_MIN = 1;
  localparam int unsigned STAGES_MAX = 4;

  // Single-bit evaluation; the top applies it across the operand width.
  function automatic logic gate_eval(input gate_op_e op, input logic a, input logic b);
    logic r;
    case (op)
      GATE_NAND:  r = ~(a & b);
      GATE_AND:   r = a & b;
      GATE_OR:    r = a | b;
      GATE_NOR:   r = ~(a | b);
      GATE_XOR:   r = a ^ b;
      GATE_XNOR:  r = ~(a ^ b);
      GATE_NOT_A: r = ~a;
      GATE_BUF_A: r = a;
      default:    r = a;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_pipe_stage.sv
// One elastic register stage: loads whenever it is empty or its successor advances.
module gate_pipe_stage #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  input  logic [W-1:0] data_i,
  output logic         ready_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  input  logic         ready_i
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         adv_c;

  assign adv_c = !valid_q || ready_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (adv_c) begin
      valid_d = valid_i;
      if (valid_i) data_d = data_i;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign ready_o = adv_c;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/gate_array_pipe.sv
// Bitwise gate array with an elastic STAGES-deep result pipeline, parity and
// a saturating count of completed output transfers.
module gate_array_pipe
  import gate_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2,
  parameter int unsigned CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_par,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] out_cnt
);

  localparam int unsigned PW = WIDTH + 1;

  logic [WIDTH-1:0] res_c;
  logic             par_c;
  logic             valid_s [STAGES+1];
  logic             ready_s [STAGES+1];
  logic [PW-1:0]    data_s  [STAGES+1];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             out_xfer_c;

  always_comb begin
    res_c = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      res_c[i] = gate_eval(gate_op_e'(op), a[i], b[i]);
    end
  end

  // Parity travels with the result so the output never recomputes it.
  assign par_c      = ^res_c;
  assign valid_s[0] = in_valid;
  assign data_s[0]  = {par_c, res_c};
  assign ready_s[STAGES] = out_ready;

  for (genvar i = 0; i < int'(STAGES); i++) begin : g_stage
    gate_pipe_stage #(.W(PW)) u_stage (
      .clk     (clk),
      .rst     (rst),
      .valid_i (valid_s[i]),
      .data_i  (data_s[i]),
      .ready_o (ready_s[i]),
      .valid_o (valid_s[i+1]),
      .data_o  (data_s[i+1]),
      .ready_i (ready_s[i+1])
    );
  end

  assign in_ready   = ready_s[0] && !rst;
  assign out_valid  = valid_s[STAGES];
  assign y          = data_s[STAGES][WIDTH-1:0];
  assign y_par      = data_s[STAGES][WIDTH];
  assign out_xfer_c = out_valid && out_ready;

  // Clear has priority over a coincident transfer; count holds at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (out_xfer_c && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign out_cnt = cnt_q;

endmodule
